// File: rtl/note_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// note_sequencer : steps through a 16-entry {tone, duration} table, driving
//                  tone_gen with timed notes separated by silent gaps.
// Revision 1.0
// ---------------------------------------------------------------------------
module note_sequencer #(
  parameter logic [31:0] CLOCK_SPEED = 32'd25_000_000,
  parameter int unsigned TICK_HZ     = 100,
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned GAP_TICKS   = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_en,
  input  logic [3:0] wr_addr,
  input  logic [3:0] wr_tone,
  input  logic [7:0] wr_dur,
  input  logic [4:0] length,
  input  logic       start,
  input  logic       stop,
  input  logic       loop,
  output logic [3:0] tone,
  output logic       busy,
  output logic [3:0] note_idx,
  output logic       done
);

  localparam int unsigned TICK_CYCLES = CLOCK_SPEED / TICK_HZ;
  localparam int unsigned PW          = $clog2(TICK_CYCLES);
  localparam int unsigned GW          = (GAP_TICKS < 2) ? 1 : $clog2(GAP_TICKS + 1);
  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_CYCLES - 1);
  localparam logic [GW-1:0] GAP_INIT  = GW'(GAP_TICKS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NOTE = 2'd1,
    GAP  = 2'd2
  } state_e;

  logic [3:0] mem_tone_q [DEPTH];
  logic [3:0] mem_tone_d [DEPTH];
  logic [7:0] mem_dur_q  [DEPTH];
  logic [7:0] mem_dur_d  [DEPTH];

  state_e        state_q, state_d;
  logic [3:0]    tone_q, tone_d;
  logic [3:0]    idx_q, idx_d;
  logic [4:0]    len_q, len_d;
  logic [7:0]    dur_cnt_q, dur_cnt_d;
  logic [GW-1:0] gap_cnt_q, gap_cnt_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          done_q, done_d;

  logic       tick;
  logic       advance;
  logic       more;
  logic [3:0] next_idx;
  logic [4:0] len_clamped;

  // A zero duration still has to occupy one tick.
  function automatic logic [7:0] dur_min1(input logic [7:0] d);
    return (d == 8'd0) ? 8'd1 : d;
  endfunction

  always_comb begin
    mem_tone_d = mem_tone_q;
    mem_dur_d  = mem_dur_q;
    if (wr_en) begin
      mem_tone_d[wr_addr] = wr_tone;
      mem_dur_d[wr_addr]  = wr_dur;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_tone_q[i] <= 4'd0;
        mem_dur_q[i]  <= 8'd0;
      end
    end else begin
      mem_tone_q <= mem_tone_d;
      mem_dur_q  <= mem_dur_d;
    end
  end

  assign tick        = (state_q != IDLE) && (presc_q == TICK_LAST);
  assign len_clamped = (length > 5'd16) ? 5'd16 : length;
  assign more        = ({1'b0, idx_q} < (len_q - 5'd1));

  always_comb begin
    state_d   = state_q;
    tone_d    = tone_q;
    idx_d     = idx_q;
    len_d     = len_q;
    dur_cnt_d = dur_cnt_q;
    gap_cnt_d = gap_cnt_q;
    done_d    = 1'b0;
    advance   = 1'b0;
    next_idx  = 4'd0;
    presc_d   = (state_q == IDLE || tick) ? '0 : presc_q + PW'(1);

    case (state_q)
      IDLE: begin
        if (start && !stop && (length != 5'd0)) begin
          len_d     = len_clamped;
          idx_d     = 4'd0;
          tone_d    = mem_tone_q[0];
          dur_cnt_d = dur_min1(mem_dur_q[0]);
          presc_d   = '0;
          state_d   = NOTE;
        end
      end
      NOTE: begin
        if (tick) begin
          if (dur_cnt_q <= 8'd1) begin
            if (GAP_TICKS != 0) begin
              tone_d    = 4'd0;
              gap_cnt_d = GAP_INIT;
              state_d   = GAP;
            end else begin
              advance = 1'b1;
            end
          end else begin
            dur_cnt_d = dur_cnt_q - 8'd1;
          end
        end
      end
      GAP: begin
        if (tick) begin
          if (gap_cnt_q <= GW'(1)) advance = 1'b1;
          else                     gap_cnt_d = gap_cnt_q - GW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // End of a note (and its gap): next entry, wrap on loop, or finish the pass.
    if (advance) begin
      if (more) next_idx = idx_q + 4'd1;
      if (more || loop) begin
        idx_d     = next_idx;
        tone_d    = mem_tone_q[next_idx];
        dur_cnt_d = dur_min1(mem_dur_q[next_idx]);
        state_d   = NOTE;
      end else begin
        tone_d  = 4'd0;
        done_d  = 1'b1;
        state_d = IDLE;
      end
    end

    if (stop && (state_q != IDLE)) begin
      tone_d  = 4'd0;
      done_d  = 1'b0;
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      tone_q    <= 4'd0;
      idx_q     <= 4'd0;
      len_q     <= 5'd0;
      dur_cnt_q <= 8'd0;
      gap_cnt_q <= '0;
      presc_q   <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      tone_q    <= tone_d;
      idx_q     <= idx_d;
      len_q     <= len_d;
      dur_cnt_q <= dur_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      presc_q   <= presc_d;
      done_q    <= done_d;
    end
  end

  assign tone     = tone_q;
  assign busy     = (state_q != IDLE);
  assign note_idx = idx_q;
  assign done     = done_q;

endmodule
`default_nettype wire

// File: tb/tb_note_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_note_sequencer : directed and randomized playback scenarios checked
//                     against a per-cycle timeline built from the note table.
// Revision 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_note_sequencer;

  localparam int T   = 10;  // clock cycles per tick
  localparam int GAP = 1;   // silent ticks after every note

  logic       clk     = 1'b0;
  logic       rst_n   = 1'b0;
  logic       wr_en   = 1'b0;
  logic [3:0] wr_addr = 4'd0;
  logic [3:0] wr_tone = 4'd0;
  logic [7:0] wr_dur  = 8'd0;
  logic [4:0] length  = 5'd0;
  logic       start   = 1'b0;
  logic       stop    = 1'b0;
  logic       loop    = 1'b0;
  logic [3:0] tone;
  logic       busy;
  logic [3:0] note_idx;
  logic       done;

  int checks   = 0;
  int failures = 0;
  int m_tone [16];
  int m_dur  [16];

  always #5 clk = ~clk;

  note_sequencer #(
    .CLOCK_SPEED(32'd100),
    .TICK_HZ    (10),
    .DEPTH      (16),
    .GAP_TICKS  (1)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_tone (wr_tone),
    .wr_dur  (wr_dur),
    .length  (length),
    .start   (start),
    .stop    (stop),
    .loop    (loop),
    .tone    (tone),
    .busy    (busy),
    .note_idx(note_idx),
    .done    (done)
  );

  task automatic chk(input string tag, input int et, input int eb, input int ei, input int ed);
    checks++;
    assert ({tone, busy, note_idx, done} === {4'(et), 1'(eb), 4'(ei), 1'(ed)})
      else begin
        failures++;
        $error("FAIL %s: observed tone=%0d busy=%0d idx=%0d done=%0d, expected tone=%0d busy=%0d idx=%0d done=%0d",
               tag, tone, busy, note_idx, done, et, eb, ei, ed);
      end
  endtask

  // Check n consecutive cycles with no done pulse, advancing one negedge each.
  task automatic hold(input string tag, input int n, input int et, input int eb, input int ei);
    for (int k = 0; k < n; k++) begin
      chk(tag, et, eb, ei, 0);
      @(negedge clk);
    end
  endtask

  function automatic int ticks(input int d);
    return (d == 0) ? 1 : d;
  endfunction

  task automatic play_note(input string tag, input int i);
    hold(tag, ticks(m_dur[i]) * T, m_tone[i], 1, i);
    hold({tag, "_gap"}, GAP * T, 0, 1, i);
  endtask

  task automatic finish_pass(input string tag, input int last);
    chk({tag, "_done"}, 0, 0, last, 1);
    @(negedge clk);
    chk({tag, "_idle"}, 0, 0, last, 0);
  endtask

  task automatic wr(input int a, input int t, input int d);
    wr_en = 1'b1; wr_addr = 4'(a); wr_tone = 4'(t); wr_dur = 8'(d);
    @(negedge clk);
    wr_en = 1'b0;
    m_tone[a] = t;
    m_dur[a]  = d;
  endtask

  task automatic do_start(input int len);
    length = 5'(len);
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int len, told, tnew, dnew;
    for (int i = 0; i < 16; i++) begin
      m_tone[i] = 0;
      m_dur[i]  = 0;
    end

    // Reset state
    repeat (2) @(negedge clk);
    chk("reset", 0, 0, 0, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_rel", 0, 0, 0, 0);

    // Basic two-note pass
    wr(0, 1, 2);
    wr(1, 8, 3);
    loop = 1'b0;
    do_start(2);
    play_note("t1_e0", 0);
    play_note("t1_e1", 1);
    finish_pass("t1", 1);

    // Looping, then loop dropped during the second pass
    loop = 1'b1;
    do_start(2);
    play_note("t2_e0", 0);
    play_note("t2_e1", 1);
    hold("t2_wrap", 5, 1, 1, 0);
    loop = 1'b0;
    hold("t2_e0b", 15, 1, 1, 0);
    hold("t2_e0b_gap", GAP * T, 0, 1, 0);
    play_note("t2_e1b", 1);
    finish_pass("t2", 1);

    // Stop part-way through e1, then restart from e0
    do_start(2);
    play_note("t3_e0", 0);
    hold("t3_e1", 15, 8, 1, 1);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    chk("t3_stop", 0, 0, 1, 0);
    @(negedge clk);
    hold("t3_idle", 3, 0, 0, 1);
    do_start(2);
    play_note("t3_re_e0", 0);
    play_note("t3_re_e1", 1);
    finish_pass("t3", 1);

    // Zero-duration entry plays one tick
    wr(2, 5, 0);
    do_start(3);
    play_note("t4_e0", 0);
    play_note("t4_e1", 1);
    play_note("t4_dur0", 2);
    finish_pass("t4_dur0", 2);

    // length==0 start is ignored
    @(negedge clk);
    do_start(0);
    hold("t4_len0", 5, 0, 0, 2);

    // start and stop together in IDLE
    length = 5'd2; start = 1'b1; stop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    hold("t4_startstop", 5, 0, 0, 2);

    // length 20 clamps to 16 over a random table; extra start while busy
    for (int a = 0; a < 16; a++) wr(a, $urandom_range(0, 15), $urandom_range(0, 3));
    do_start(20);
    hold("t4_busy_a", 3, m_tone[0], 1, 0);
    start = 1'b1;
    hold("t4_busy_start", 1, m_tone[0], 1, 0);
    start = 1'b0;
    hold("t4_busy_b", ticks(m_dur[0]) * T - 4, m_tone[0], 1, 0);
    hold("t4_busy_gap", GAP * T, 0, 1, 0);
    for (int i = 1; i < 16; i++) play_note("t4_len20", i);
    finish_pass("t4_len20", 15);

    // Random length over the same table
    len = $urandom_range(1, 16);
    do_start(len);
    for (int i = 0; i < len; i++) play_note("t4_rnd", i);
    finish_pass("t4_rnd", len - 1);

    // Overwrite the playing entry: takes effect on the next pass
    told = $urandom_range(1, 15);
    tnew = (told % 15) + 1;
    dnew = $urandom_range(1, 3);
    wr(0, told, 3);
    loop = 1'b1;
    do_start(1);
    hold("t5_old_a", 5, told, 1, 0);
    wr_en = 1'b1; wr_addr = 4'd0; wr_tone = 4'(tnew); wr_dur = 8'(dnew);
    hold("t5_wr", 1, told, 1, 0);
    wr_en = 1'b0;
    hold("t5_old_b", 24, told, 1, 0);
    hold("t5_gap", GAP * T, 0, 1, 0);
    m_tone[0] = tnew;
    m_dur[0]  = dnew;
    hold("t5_new_a", 5, tnew, 1, 0);
    loop = 1'b0;
    hold("t5_new_b", ticks(dnew) * T - 5, tnew, 1, 0);
    hold("t5_new_gap", GAP * T, 0, 1, 0);
    finish_pass("t5", 0);

    // Async reset during a gap clears outputs and the table
    wr(0, $urandom_range(1, 15), 1);
    wr(1, $urandom_range(1, 15), 2);
    do_start(2);
    hold("t6_e0", T, m_tone[0], 1, 0);
    hold("t6_gap", 4, 0, 1, 0);
    #2 rst_n = 1'b0;
    #1 chk("t6_async", 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) begin
      m_tone[i] = 0;
      m_dur[i]  = 0;
    end
    @(negedge clk);
    rst_n = 1'b1;
    chk("t6_after", 0, 0, 0, 0);
    @(negedge clk);
    do_start(1);
    play_note("t6_rest", 0);
    finish_pass("t6", 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
